// File: rtl/cic_interpolator_if.sv
// Sample stream bundle for cic_interpolator.
//   in / in_valid   : upstream sample offered to the filter
//   in_ready        : filter takes a sample this cycle (one slot per frame)
//   out / out_valid : interpolated sample stream, one per clock
//   underrun        : sticky flag, a slot passed with no sample offered
// master drives the input side; slave is the filter.
interface cic_interpolator_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             underrun;

    modport master (
        output in, in_valid,
        input  in_ready, out, out_valid, underrun
    );

    modport slave (
        input  in, in_valid,
        output in_ready, out, out_valid, underrun
    );
endinterface

// File: rtl/cic_interpolator.sv
// CIC interpolation filter: STAGES comb sections at the frame rate, a
// zero-stuffing upsampler, then STAGES integrators at the full clock rate.
// Unsigned WIDTH-bit samples are upsampled by RATE with unity DC gain.
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   bus  : slave side of cic_interpolator_if (in/in_valid/in_ready,
//          out/out_valid, sticky underrun)
module cic_interpolator #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int RATE   = 4
) (
    input logic               clk,
    input logic               rst,
    cic_interpolator_if.slave bus
);
    localparam int LOG_RATE   = $clog2(RATE);
    localparam int REGS_WIDTH = WIDTH + STAGES * LOG_RATE;
    localparam int SHIFT      = (STAGES - 1) * LOG_RATE;

    logic [LOG_RATE-1:0]   ph;
    logic                  strobe;
    logic                  accept;
    logic [REGS_WIDTH-1:0] s;
    logic [REGS_WIDTH-1:0] c     [0:STAGES];
    logic [REGS_WIDTH-1:0] d     [1:STAGES];
    logic [REGS_WIDTH-1:0] up;
    logic [REGS_WIDTH-1:0] integ [1:STAGES];
    logic [STAGES:0]       vpipe;
    logic                  underrun_r;

    always_comb begin
        strobe = (ph == '0);
        accept = strobe & bus.in_valid;
        // A slot without a sample feeds zero into the combs.
        s = accept ? {{(REGS_WIDTH - WIDTH){1'b0}}, bus.in} : '0;
    end

    always_comb begin
        c[0] = s;
        for (int unsigned k = 1; k <= STAGES; k++) begin
            c[k] = c[k-1] - d[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph         <= '0;
            up         <= '0;
            vpipe      <= '0;
            underrun_r <= 1'b0;
            for (int unsigned k = 1; k <= STAGES; k++) begin
                d[k]     <= '0;
                integ[k] <= '0;
            end
        end else begin
            // RATE is a power of two, so the counter wraps naturally.
            ph <= ph + 1'b1;
            if (strobe) begin
                for (int unsigned k = 1; k <= STAGES; k++) begin
                    d[k] <= c[k-1];
                end
                if (!bus.in_valid) begin
                    underrun_r <= 1'b1;
                end
            end
            up       <= strobe ? c[STAGES] : '0;
            integ[1] <= integ[1] + up;
            for (int unsigned k = 2; k <= STAGES; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
            // Bit 0 latches the first accepted sample; bit k follows k edges
            // later, lining out_valid up with the integrator latency.
            vpipe <= {vpipe[STAGES-1:0], vpipe[0] | accept};
        end
    end

    // Wrap-around in the integrators cancels exactly; only the final scaled
    // window is exported.
    assign bus.out       = integ[STAGES][SHIFT +: WIDTH];
    assign bus.in_ready  = strobe;
    assign bus.out_valid = vpipe[STAGES];
    assign bus.underrun  = underrun_r;
endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator. Three instances share one
// stimulus stream: (STAGES=1,RATE=4), (STAGES=2,RATE=4), (STAGES=3,RATE=8).
// Expected output sequences are queued per instance before each stimulus
// run; a monitor per instance pops one entry for every out_valid cycle.
module tb_cic_interpolator;
    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] din  = '0;
    logic       dval = 1'b0;

    always #5 clk = ~clk;

    cic_interpolator_if #(.WIDTH(8)) b1 ();
    cic_interpolator_if #(.WIDTH(8)) b2 ();
    cic_interpolator_if #(.WIDTH(8)) b3 ();

    assign b1.in = din;  assign b1.in_valid = dval;
    assign b2.in = din;  assign b2.in_valid = dval;
    assign b3.in = din;  assign b3.in_valid = dval;

    cic_interpolator #(.WIDTH(8), .STAGES(1), .RATE(4)) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    cic_interpolator #(.WIDTH(8), .STAGES(2), .RATE(4)) dut2 (
        .clk(clk), .rst(rst), .bus(b2)
    );
    cic_interpolator #(.WIDTH(8), .STAGES(3), .RATE(8)) dut3 (
        .clk(clk), .rst(rst), .bus(b3)
    );

    typedef struct packed {
        logic [7:0] v;
        logic       care;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int dut, input int val, input int n, input logic care);
        exp_t e;
        e.v    = val[7:0];
        e.care = care;
        repeat (n) begin
            case (dut)
                1:       q1.push_back(e);
                2:       q2.push_back(e);
                default: q3.push_back(e);
            endcase
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b1.out_valid && q1.size() != 0) begin
            e = q1.pop_front();
            if (e.care) check("s1_out", int'(b1.out), int'(e.v));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b2.out_valid && q2.size() != 0) begin
            e = q2.pop_front();
            if (e.care) check("s2_out", int'(b2.out), int'(e.v));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b3.out_valid && q3.size() != 0) begin
            e = q3.pop_front();
            if (e.care) check("s3_out", int'(b3.out), int'(e.v));
        end
    end

    // Returns just after the releasing edge; the current cycle is slot 0.
    task automatic do_reset();
        @(posedge clk); #1;
        rst  = 1'b1;
        dval = 1'b0;
        din  = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drive(input int n, input logic v, input logic [7:0] d);
        repeat (n) begin
            dval = v;
            din  = d;
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int i = 0;
        while (i < 200 && (q1.size() + q2.size() + q3.size()) != 0) begin
            @(posedge clk); #1;
            i++;
        end
        check("drain_empty", q1.size() + q2.size() + q3.size(), 0);
        q1.delete();
        q2.delete();
        q3.delete();
    endtask

    initial begin
        int tri_exp[10];
        tri_exp = '{2, 4, 6, 8, 6, 4, 2, 0, 0, 0};

        // Power-on reset state.
        @(negedge clk);
        check("por_out",       int'(b1.out), 0);
        check("por_out_valid", int'(b1.out_valid), 0);
        check("por_underrun",  int'(b1.underrun), 0);
        check("por_in_ready",  int'(b1.in_ready), 1);

        // Impulse of 8: zero-order hold for STAGES=1, triangle for STAGES=2.
        do_reset();
        push(1, 8, 4, 1'b1);
        push(1, 0, 8, 1'b1);
        foreach (tri_exp[i]) push(2, tri_exp[i], 1, 1'b1);
        drive(4, 1'b1, 8'd8);
        drive(20, 1'b1, 8'd0);
        drain();

        // Step of 10.
        do_reset();
        push(1, 10, 16, 1'b1);
        push(2, 2, 1, 1'b1);
        push(2, 5, 1, 1'b1);
        push(2, 7, 1, 1'b1);
        push(2, 10, 13, 1'b1);
        drive(24, 1'b1, 8'd10);
        drain();

        // Full-scale DC: internal wrap must not disturb the settled output.
        do_reset();
        push(3, 0, 32, 1'b0);
        push(3, 255, 48, 1'b1);
        push(1, 255, 20, 1'b1);
        push(2, 63, 1, 1'b1);
        push(2, 127, 1, 1'b1);
        push(2, 191, 1, 1'b1);
        push(2, 255, 13, 1'b1);
        drive(104, 1'b1, 8'd255);
        drain();

        // Handshake: in_valid held high, in increments each cycle; only the
        // slot values (cycles 0,4,8,...) are taken.
        do_reset();
        for (int f = 0; f < 5; f++) push(1, 1 + 4 * f, 4, 1'b1);
        for (int c = 0; c < 24; c++) drive(1, 1'b1, 8'(c + 1));
        drain();
        check("hs_underrun", int'(b1.underrun), 0);

        // Underrun: slot of frame 2 missed during constant 10.
        do_reset();
        push(1, 10, 8, 1'b1);
        push(1, 0, 4, 1'b1);
        push(1, 10, 8, 1'b1);
        for (int c = 0; c < 24; c++) begin
            dval = !(c >= 8 && c < 12);
            din  = 8'd10;
            @(negedge clk);
            if (c == 8) check("ur_before", int'(b1.underrun), 0);
            if (c == 9) check("ur_after", int'(b1.underrun), 1);
            if (c >= 8 && c < 16) check("ur_out_valid", int'(b1.out_valid), 1);
            @(posedge clk); #1;
        end
        check("ur_sticky", int'(b1.underrun), 1);
        check("ur_valid_hold", int'(b1.out_valid), 1);
        drain();

        // Mid-stream reset: state clears immediately, then phase restarts.
        rst  = 1'b1;
        dval = 1'b1;
        din  = 8'd10;
        @(negedge clk);
        check("rst_out",        int'(b1.out), 0);
        check("rst_out_valid",  int'(b1.out_valid), 0);
        check("rst_underrun",   int'(b1.underrun), 0);
        check("rst_in_ready",   int'(b1.in_ready), 1);
        check("rst_s2_valid",   int'(b2.out_valid), 0);
        check("rst_s3_valid",   int'(b3.out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("rel_out",       int'(b1.out), 0);
                check("rel_out_valid", int'(b1.out_valid), 0);
                check("rel_underrun",  int'(b1.underrun), 0);
            end
            check("rel_in_ready_r4", int'(b1.in_ready), (c % 4 == 0) ? 1 : 0);
            check("rel_in_ready_r8", int'(b3.in_ready), (c % 8 == 0) ? 1 : 0);
            @(posedge clk); #1;
        end
        check("rel_underrun_end", int'(b1.underrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
